// File: rtl/iobank_pkg.sv
// Shared constants for the GPIO pad bank: register indices, bus address width
// and the pad-cell names used when instantiating the IO ring.
`ifndef IOBANK_PKG_MACROS
`define IOBANK_PKG_MACROS
`define IOBANK_PAD_IO    sg13g2_IOPadInOut4mA
`define IOBANK_PAD_IOVDD sg13g2_IOPadIOVdd
`define IOBANK_PAD_IOVSS sg13g2_IOPadIOVss
`define IOBANK_PAD_VDD   sg13g2_IOPadVdd
`define IOBANK_PAD_VSS   sg13g2_IOPadVss
`endif

package iobank_pkg;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] REG_DIR       = 3'd0;
    localparam logic [ADDR_W-1:0] REG_OUT       = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IN        = 3'd2;
    localparam logic [ADDR_W-1:0] REG_IRQ_EN    = 3'd3;
    localparam logic [ADDR_W-1:0] REG_IRQ_PEND  = 3'd4;
    localparam logic [ADDR_W-1:0] REG_EDGE_MODE = 3'd5;
    localparam logic [ADDR_W-1:0] REG_OUT_SET   = 3'd6;
    localparam logic [ADDR_W-1:0] REG_OUT_CLR   = 3'd7;
endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input path: synchroniser chain, edge history, edge select and the
// sticky pending flag with write-1-to-clear.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic p2c,
    input  logic armed,
    input  logic edge_mode,
    input  logic pend_clr,
    output logic in_o,
    output logic pend_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pend_q, pend_d;
    logic                   sync_in;
    logic                   edge_det;

    always_comb begin
        sync_in  = sync_q[SYNC_STAGES-1];
        sync_d   = {sync_q[SYNC_STAGES-2:0], p2c};
        prev_d   = sync_in;
        edge_det = armed & (edge_mode ? (~sync_in & prev_q) : (sync_in & ~prev_q));
        // A fresh edge beats a simultaneous clear so no event is lost.
        pend_d   = edge_det | (pend_q & ~pend_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign in_o   = sync_in;
    assign pend_o = pend_q;
endmodule

// File: rtl/sg13g2_IOPadIOVdd.sv
// Behavioural stand-in for the IO-supply power pad (no logical ports).
module sg13g2_IOPadIOVdd ();
endmodule

// File: rtl/sg13g2_IOPadIOVss.sv
// Behavioural stand-in for the IO-ground pad (no logical ports).
module sg13g2_IOPadIOVss ();
endmodule

// File: rtl/sg13g2_IOPadInOut4mA.sv
// Behavioural stand-in for the bidirectional 4 mA pad cell.
module sg13g2_IOPadInOut4mA (
    inout  wire  pad,
    input  logic c2p,
    input  logic c2p_en,
    output logic p2c
);
    assign pad = c2p_en ? c2p : 1'bz;
    assign p2c = pad;
endmodule

// File: rtl/sg13g2_IOPadVdd.sv
// Behavioural stand-in for the core-supply power pad (no logical ports).
module sg13g2_IOPadVdd ();
endmodule

// File: rtl/sg13g2_IOPadVss.sv
// Behavioural stand-in for the core-ground pad (no logical ports).
module sg13g2_IOPadVss ();
endmodule

// File: rtl/iobank_gpio.sv
// Parametrised GPIO pad bank: pad ring, register file with set/clear access,
// synchronised inputs and per-pin edge interrupts merged into one irq.
module iobank_gpio
    import iobank_pkg::*;
#(
    parameter int NGPIO       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int NPWR        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [NGPIO-1:0]  bus_wdata,
    output logic [NGPIO-1:0]  bus_rdata,
    output logic              bus_ack,
    output logic              irq,
    inout  wire  [NGPIO-1:0]  pads
);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [NGPIO-1:0] dir_q, dir_d;
    logic [NGPIO-1:0] out_q, out_d;
    logic [NGPIO-1:0] irq_en_q, irq_en_d;
    logic [NGPIO-1:0] edge_mode_q, edge_mode_d;
    logic [NGPIO-1:0] rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;
    logic [ARM_W-1:0] arm_q, arm_d;

    logic [NGPIO-1:0] p2c, in_w, pend_w, pend_clr, c2p_en;
    logic             armed, wr, rd;

    assign armed  = (arm_q == ARM_W'(ARM_MAX));
    // Pads float as soon as reset is seen, not one edge later.
    assign c2p_en = dir_q & ~{NGPIO{rst}};

    always_comb begin
        wr          = bus_req & bus_we;
        rd          = bus_req & ~bus_we;
        dir_d       = dir_q;
        out_d       = out_q;
        irq_en_d    = irq_en_q;
        edge_mode_d = edge_mode_q;
        pend_clr    = '0;
        rdata_d     = '0;
        if (wr) begin
            case (bus_addr)
                REG_DIR:       dir_d       = bus_wdata;
                REG_OUT:       out_d       = bus_wdata;
                REG_IRQ_EN:    irq_en_d    = bus_wdata;
                REG_IRQ_PEND:  pend_clr    = bus_wdata;
                REG_EDGE_MODE: edge_mode_d = bus_wdata;
                REG_OUT_SET:   out_d       = out_q | bus_wdata;
                REG_OUT_CLR:   out_d       = out_q & ~bus_wdata;
                default:       ;
            endcase
        end
        if (rd) begin
            case (bus_addr)
                REG_DIR:       rdata_d = dir_q;
                REG_OUT:       rdata_d = out_q;
                REG_IN:        rdata_d = in_w;
                REG_IRQ_EN:    rdata_d = irq_en_q;
                REG_IRQ_PEND:  rdata_d = pend_w;
                REG_EDGE_MODE: rdata_d = edge_mode_q;
                default:       rdata_d = '0;
            endcase
        end
        ack_d = bus_req;
        irq_d = |(pend_w & irq_en_q);
        arm_d = armed ? arm_q : arm_q + ARM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q       <= '0;
            out_q       <= '0;
            irq_en_q    <= '0;
            edge_mode_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            irq_q       <= 1'b0;
            arm_q       <= '0;
        end else begin
            dir_q       <= dir_d;
            out_q       <= out_d;
            irq_en_q    <= irq_en_d;
            edge_mode_q <= edge_mode_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            irq_q       <= irq_d;
            arm_q       <= arm_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ack   = ack_q;
    assign irq       = irq_q;

    for (genvar gi = 0; gi < NGPIO; gi++) begin : g_pin
        `IOBANK_PAD_IO u_pad (
            .pad    (pads[gi]),
            .c2p    (out_q[gi]),
            .c2p_en (c2p_en[gi]),
            .p2c    (p2c[gi])
        );

        gpio_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk       (clk),
            .rst       (rst),
            .p2c       (p2c[gi]),
            .armed     (armed),
            .edge_mode (edge_mode_q[gi]),
            .pend_clr  (pend_clr[gi]),
            .in_o      (in_w[gi]),
            .pend_o    (pend_w[gi])
        );
    end

    for (genvar gi = 0; gi < NPWR; gi++) begin : g_pwr
        `IOBANK_PAD_IOVDD u_iovdd ();
        `IOBANK_PAD_IOVSS u_iovss ();
        `IOBANK_PAD_VDD   u_vdd ();
        `IOBANK_PAD_VSS   u_vss ();
    end
endmodule
